// File: rtl/gbsha_tt03_mac_pkg.sv
// Shared constants for the TT03 4-tap FIR MAC: default widths, tap count,
// coefficient/accumulator widths and the fixed coefficient set.
package gbsha_tt03_mac_pkg;

  localparam int FIR_N_TAPS = 4;
  localparam int FIR_BW_IN  = 6;
  localparam int FIR_BW_OUT = 8;
  localparam int COEF_W     = 4;
  localparam int ACC_W      = 12;

  // Coefficients are packed with h0 at index 0: h0=1, h1=3, h2=3, h3=1.
  localparam logic [FIR_N_TAPS-1:0][COEF_W-1:0] FIR_COEFS =
    {4'd1, 4'd3, 4'd3, 4'd1};

endpackage

// File: rtl/gbsha_fir_core.sv
// Direct-form FIR core: delay line, signed MAC, saturation to BW_out and
// the registered output. Nothing combinational reaches y_out.
module gbsha_fir_core
  import gbsha_tt03_mac_pkg::*;
#(
  parameter int N_TAPS = FIR_N_TAPS,
  parameter int BW_in  = FIR_BW_IN,
  parameter int BW_out = FIR_BW_OUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BW_in-1:0]  x_in,
  output logic [BW_out-1:0] y_out
);

  // Accumulator wide enough for sample * coef plus two growth bits.
  localparam int AW = (ACC_W > BW_in + COEF_W + 2) ? ACC_W : BW_in + COEF_W + 2;
  localparam logic signed [AW-1:0] YMAX = AW'((2 ** (BW_out - 1)) - 1);
  localparam logic signed [AW-1:0] YMIN = ~YMAX;

  logic [N_TAPS-1:0][BW_in-1:0] tap;
  logic [N_TAPS-1:0][AW-1:0]    prod;
  logic signed [AW-1:0]         acc;
  logic [BW_out-1:0]            y_reg;

  // Per-tap product, both operands sign-extended to the accumulator width.
  genvar k;
  generate
    for (k = 0; k < N_TAPS; k++) begin : g_tap
      logic signed [AW-1:0] tx, cx;
      assign tx      = AW'($signed(tap[k]));
      assign cx      = AW'($signed(FIR_COEFS[k]));
      assign prod[k] = tx * cx;
    end
  endgenerate

  // Delay line: newest sample enters tap[0], oldest falls off the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tap <= '0;
    else     tap <= {tap[N_TAPS-2:0], x_in};
  end

  // Sum of products over the pre-edge tap values.
  always_comb begin
    acc = '0;
    for (int i = 0; i < N_TAPS; i++) acc = acc + $signed(prod[i]);
  end

  // Clip to the signed output range and register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              y_reg <= '0;
    else if (acc > YMAX)  y_reg <= YMAX[BW_out-1:0];
    else if (acc < YMIN)  y_reg <= YMIN[BW_out-1:0];
    else                  y_reg <= acc[BW_out-1:0];
  end

  assign y_out = y_reg;

endmodule

// File: rtl/gbsha_tt03_mac_top.sv
// TT03 wrapper: maps io_in/io_out pins onto the FIR core, no logic of its own.
module gbsha_tt03_mac_top
  import gbsha_tt03_mac_pkg::*;
#(
  parameter int N_TAPS = FIR_N_TAPS,
  parameter int BW_in  = FIR_BW_IN,
  parameter int BW_out = FIR_BW_OUT
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic [BW_out-1:0] y;

  gbsha_fir_core #(
    .N_TAPS (N_TAPS),
    .BW_in  (BW_in),
    .BW_out (BW_out)
  ) u_core (
    .clk   (io_in[0]),
    .rst   (io_in[1]),
    .x_in  (io_in[2 +: BW_in]),
    .y_out (y)
  );

  // Sign-extend to the full output byte.
  assign io_out = 8'($signed(y));

endmodule

// File: tb/tb_gbsha_tt03_mac_top.sv
// Bench for the TT03 FIR MAC: table of {x, expected y-after-edge} records
// through a scoreboard queue, plus hand sequences for the reset corners.
module tb_gbsha_tt03_mac_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] x   = '0;
  logic [7:0] io_in, io_out;

  assign io_in = {x, rst, clk};

  gbsha_tt03_mac_top dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] x;
    logic [7:0] y;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  function automatic void add(input int xv, input int yv);
    vec_t v;
    v.x = 6'(xv);
    v.y = 8'(yv);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, $signed(got), $signed(want));
    end
  endtask

  // Drive one sample, queue the expected output for after the next edge,
  // then compare once the edge has settled.
  task automatic step(input logic [5:0] xv, input logic [7:0] yv, input string name);
    logic [7:0] want;
    x = xv;
    exp_q.push_back(yv);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check(name, io_out, want);
  endtask

  initial begin
    // Impulse response, then flush.
    add(1, 0); add(0, 1); add(0, 3); add(0, 3); add(0, 1); add(0, 0);
    // Step of 10, then drain.
    add(10, 0); add(10, 10); add(10, 40); add(10, 70); add(10, 80); add(10, 80);
    add(0, 80); add(0, 70); add(0, 40); add(0, 10); add(0, 0);
    // Positive saturation (217, 248 clip to 127), then drain.
    add(31, 0); add(31, 31); add(31, 124); add(31, 127); add(31, 127); add(31, 127);
    add(0, 127); add(0, 127); add(0, 124); add(0, 31); add(0, 0);
    // Negative saturation (-224, -256 clip to -128), then drain.
    add(-32, 0); add(-32, -32); add(-32, -128); add(-32, -128); add(-32, -128); add(-32, -128);
    add(0, -128); add(0, -128); add(0, -128); add(0, -32); add(0, 0);
    // Mixed signs.
    add(5, 0); add(-3, 5); add(0, 12); add(0, 6); add(0, -4); add(0, -3); add(0, 0);

    // Reset held with arbitrary input across several edges.
    #1;
    check("reset_initial", io_out, 8'h00);
    for (int i = 0; i < 3; i++) step(6'($urandom_range(0, 63)), 8'h00, "reset_hold");
    rst = 1'b0;

    // Table-driven vectors.
    foreach (vecs[i]) step(vecs[i].x, vecs[i].y, $sformatf("vec%0d", i));

    // Build up history, then assert reset between edges.
    for (int i = 0; i < 5; i++) step(6'd10, (i == 0) ? 8'd0 : (i == 1) ? 8'd10 :
                                        (i == 2) ? 8'd40 : (i == 3) ? 8'd70 : 8'd80, "pre_rst_step");
    #2;
    rst = 1'b1;
    #1;
    check("async_clear", io_out, 8'h00);
    step(6'd10, 8'h00, "rst_held_edge");
    rst = 1'b0;

    // First edge after release captures x; output stays 0 until the next one.
    step(6'd7, 8'd0,  "post_rst_e1");
    step(6'd0, 8'd7,  "post_rst_e2");
    step(6'd0, 8'd21, "post_rst_e3");
    step(6'd0, 8'd21, "post_rst_e4");
    step(6'd0, 8'd7,  "post_rst_e5");
    step(6'd0, 8'd0,  "post_rst_e6");

    // Step, pulse reset, then zeros: no history may come back.
    for (int i = 0; i < 5; i++) step(6'd10, (i == 0) ? 8'd0 : (i == 1) ? 8'd10 :
                                        (i == 2) ? 8'd40 : (i == 3) ? 8'd70 : 8'd80, "step2");
    #2;
    rst = 1'b1;
    #1;
    check("midstream_clear", io_out, 8'h00);
    #4;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(6'd0, 8'd0, "no_history");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gbsha_tt03_mac_top.md
GBSHA_TT03_MAC_TOP -- requirements
Module: gbsha_tt03_mac_top

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; both are carried on io_in bits, named as below.
REQ-002 Parameter N_TAPS, default 4, SHALL set the number of FIR taps.
REQ-003 Parameter BW_in, default 6, SHALL set the signed sample input width.
REQ-004 Parameter BW_out, default 8, SHALL set the signed output width.
REQ-005 io_in[0] (clk), input, 1 bit: rising-edge clock.
REQ-006 io_in[1] (rst), input, 1 bit: asynchronous active-high reset.
REQ-007 io_in[7:2] (x_in), input, 6 bits: two's-complement sample; bits above BW_in+1 SHALL be ignored if BW_in < 6.
REQ-008 io_out[7:0] (y_out), output, 8 bits: two's-complement filtered sample, y_out = io_out[BW_out-1:0].
REQ-009 The ports SHALL be exactly io_in[7:0] and io_out[7:0]; no other ports, apart from the gate-level power pins vccd1/vssd1.

Function
REQ-010 The block SHALL be a direct-form FIR with fixed signed coefficients h0=1, h1=3, h2=3, h3=1, each 4 bits wide.
REQ-011 Delay line, on each rising clk: tap[0] <= x_in and tap[k] <= tap[k-1] for k=1..N_TAPS-1.
REQ-012 Output register, on each rising clk: y_reg <= sat(sum over k of h_k*tap[k]), using the tap values before that edge.
REQ-013 Latency: a sample present at edge t SHALL contribute h0*x at y_out after edge t+1, h1*x after edge t+2, and so on to h3*x after edge t+4.
REQ-014 Products and the sum SHALL be computed in at least 12-bit signed arithmetic (BW_in + 4 coefficient bits + 2 growth bits) with no intermediate overflow.
REQ-015 Saturation: sums above +127 SHALL output 127; sums below -128 SHALL output -128; otherwise the exact value SHALL be output.
REQ-016 y_out SHALL be driven only from y_reg, with no combinational path from x_in to io_out.
REQ-017 The block SHALL sample x_in every cycle; there is no handshake or valid signal.

Reset
REQ-018 When rst=1, all taps and y_reg SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-019 While rst is held, io_out SHALL read 0x00.
REQ-020 After rst deasserts, the first rising clk SHALL capture x_in into tap[0]; y_out SHALL stay 0 until the following edge.
REQ-021 Reset asserted mid-stream SHALL discard all history; no pre-reset sample SHALL ever reappear at the output.

Structure
REQ-022 A shared package SHALL hold N_TAPS, BW_in, BW_out, the coefficient width (4), the accumulator width (12) and the coefficient array.
REQ-023 One sub-module, gbsha_fir_core, SHALL hold the delay line, the MAC sum, the saturation and y_reg, with ports clk, rst, x_in, y_out.
REQ-024 gbsha_tt03_mac_top SHALL only map io_in and io_out bits to gbsha_fir_core.

Verification
REQ-025 Reset: rst=1 with arbitrary x_in, then toggle clk -> io_out=0x00 throughout; async assertion mid-cycle clears io_out with no clk edge.
REQ-026 Impulse: x_in=1 for one cycle, then 0 -> y_out after edges 1..5 = 1, 3, 3, 1, 0.
REQ-027 Step: x_in=10 held -> y_out = 10, 40, 70, then 80 steady.
REQ-028 Positive saturation: x_in=31 held -> y_out = 31, 124, 127 (217 clipped), then 127 steady.
REQ-029 Negative saturation: x_in=-32 held -> y_out = -32, -128 (exact), then -128 steady (-224 and -256 clipped).
REQ-030 Reset mid-stream: after the step x_in=10, pulse rst, then apply x_in=0 -> y_out=0 immediately and on every later edge.
